// File: rtl/bcd_acc_pkg.sv
// ============================================================================
// Module   : bcd_acc_pkg
// Purpose  : Shared types and constants for the BCD accumulator controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_acc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADD_ONES = 2'd1,
        ADD_TENS = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segment patterns, bit0=a .. bit6=g, index = digit.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        if (digit > DIGIT_MAX) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[digit];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adder.sv
// ============================================================================
// Module   : bcd_digit_adder
// Purpose  : Combinational single-digit decimal-corrected adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw_sum;
    logic [4:0] adj_sum;

    always_comb begin
        raw_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        adj_sum = raw_sum - 5'd10;
        if (raw_sum > 5'd9) begin
            sum  = adj_sum[3:0];
            cout = 1'b1;
        end else begin
            sum  = raw_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_accumulator_ctrl.sv
// ============================================================================
// Module   : bcd_accumulator_ctrl
// Purpose  : Sequenced two-digit BCD running total driving HEX0/HEX1.
//            Optional macro BCD_SATURATE_EN clamps at 99 instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_accumulator_ctrl
    import bcd_acc_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       clear,
    output logic       sum_valid,
    output logic       ovf,
    output logic       err,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    function automatic logic [6:0] apply_pol(input logic [6:0] seg);
        return SEG_ACTIVE_LOW ? ~seg : seg;
    endfunction

    state_t     state_q;
    logic [3:0] opnd_q;
    logic [3:0] d0_q;
    logic [3:0] d1_q;
    logic       carry_q;
    logic       in_ready_q;
    logic       sum_valid_q;
    logic       ovf_q;
    logic       err_q;
    logic [6:0] hex0_q;
    logic [6:0] hex1_q;

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [6:0] hex0_d;
    logic [6:0] hex1_d;

    // The single adder serves the ones phase (d0+operand) and the tens phase (d1+carry).
    always_comb begin
        add_a   = d0_q;
        add_b   = opnd_q;
        add_cin = 1'b0;
        if (state_q == ADD_TENS) begin
            add_a   = d1_q;
            add_b   = 4'd0;
            add_cin = carry_q;
        end
    end

    bcd_digit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        hex0_d = apply_pol(digit_to_seg(d0_q));
        hex1_d = apply_pol((d1_q == 4'd0) ? SEG_BLANK : digit_to_seg(d1_q));
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            opnd_q      <= 4'd0;
            d0_q        <= 4'd0;
            d1_q        <= 4'd0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            hex0_q      <= apply_pol(digit_to_seg(4'd0));
            hex1_q      <= apply_pol(SEG_BLANK);
        end else if (clear) begin
            state_q     <= IDLE;
            opnd_q      <= 4'd0;
            d0_q        <= 4'd0;
            d1_q        <= 4'd0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            hex0_q      <= apply_pol(digit_to_seg(4'd0));
            hex1_q      <= apply_pol(SEG_BLANK);
        end else begin
            err_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        opnd_q <= in_data;
                        if (in_data > DIGIT_MAX) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= ADD_ONES;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ADD_ONES: begin
                    d0_q    <= add_sum;
                    carry_q <= add_cout;
                    state_q <= ADD_TENS;
                end
                ADD_TENS: begin
                    if (add_cout) begin
                        ovf_q <= 1'b1;
`ifdef BCD_SATURATE_EN
                        d1_q  <= DIGIT_MAX;
                        d0_q  <= DIGIT_MAX;
`else
                        d1_q  <= 4'd0;
`endif
                    end else begin
                        d1_q <= add_sum;
                    end
                    sum_valid_q <= 1'b1;
                    state_q     <= COMMIT;
                end
                COMMIT: begin
                    hex0_q     <= hex0_d;
                    hex1_q     <= hex1_d;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign sum_valid = sum_valid_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign HEX0      = hex0_q;
    assign HEX1      = hex1_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_accumulator_ctrl.sv
// ============================================================================
// Module   : tb_bcd_accumulator_ctrl
// Purpose  : Self-checking bench for bcd_accumulator_ctrl (either BCD_SATURATE_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_accumulator_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data  = 4'd0;
    logic       clear    = 1'b0;
    logic       in_ready;
    logic       sum_valid;
    logic       ovf;
    logic       err;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_accumulator_ctrl #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .sum_valid (sum_valid),
        .ovf       (ovf),
        .err       (err),
        .HEX0      (HEX0),
        .HEX1      (HEX1)
    );

`ifdef BCD_SATURATE_EN
    localparam int T_OVF1 = 99;
    localparam int T_OVF2 = 99;
`else
    localparam int T_OVF1 = 1;
    localparam int T_OVF2 = 9;
`endif

    // Hand-written active-high patterns; the board is active-low, so the bench inverts.
    localparam logic [6:0] TB_SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] seg_lo(input int dig, input bit blank);
        return blank ? 7'h7F : ~TB_SEG[dig];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_total(input string name, input int total);
        chk({name, ".hex0"}, 32'(HEX0), 32'(seg_lo(total % 10, 1'b0)));
        chk({name, ".hex1"}, 32'(HEX1), 32'(seg_lo(total / 10, (total / 10) == 0)));
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input int total, input bit exp_ovf, input string tag);
        bit illegal;
        int k;
        illegal = (d > 4'd9);
        k = 0;
        while (!in_ready && k < 20) begin
            tick;
            k++;
        end
        chk({tag, ".ready0"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick;
        in_valid = 1'b0;
        in_data  = 4'd0;
        chk({tag, ".err"}, 32'(err), 32'(illegal));
        chk({tag, ".ready1"}, 32'(in_ready), 32'(illegal));
        tick;
        chk({tag, ".sv2"}, 32'(sum_valid), 32'd0);
        tick;
        chk({tag, ".sv3"}, 32'(sum_valid), 32'(!illegal));
        chk({tag, ".ovf3"}, 32'(ovf), 32'(exp_ovf));
        tick;
        chk({tag, ".sv4"}, 32'(sum_valid), 32'd0);
        chk({tag, ".ready4"}, 32'(in_ready), 32'd1);
        chk({tag, ".ovf4"}, 32'(ovf), 32'(exp_ovf));
        chk_total(tag, total);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk({tag, ".clr_ovf"}, 32'(ovf), 32'd0);
        chk({tag, ".clr_rdy"}, 32'(in_ready), 32'd1);
        chk_total({tag, ".clr"}, 0);
    endtask

    typedef struct {
        logic [3:0] opnd;
        bit         clr;
        int         total;
        bit         ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] opnd, input bit clr, input int total, input bit o);
        vec_t v;
        v.opnd  = opnd;
        v.clr   = clr;
        v.total = total;
        v.ovf   = o;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sv_mask;
        logic [15:0] rdy_mask;

        add_vec(4'd7,  1'b0, 7,  1'b0);
        add_vec(4'd5,  1'b1, 5,  1'b0);
        add_vec(4'd7,  1'b0, 12, 1'b0);
        add_vec(4'd12, 1'b0, 12, 1'b0);
        add_vec(4'd9,  1'b0, 21, 1'b0);
        add_vec(4'd0,  1'b0, 21, 1'b0);
        add_vec(4'd15, 1'b0, 21, 1'b0);
        add_vec(4'd9,  1'b1, 9,  1'b0);
        add_vec(4'd9,  1'b0, 18, 1'b0);
        add_vec(4'd9,  1'b0, 27, 1'b0);
        add_vec(4'd9,  1'b0, 36, 1'b0);
        add_vec(4'd9,  1'b0, 45, 1'b0);
        add_vec(4'd9,  1'b0, 54, 1'b0);
        add_vec(4'd9,  1'b0, 63, 1'b0);
        add_vec(4'd9,  1'b0, 72, 1'b0);
        add_vec(4'd9,  1'b0, 81, 1'b0);
        add_vec(4'd9,  1'b0, 90, 1'b0);
        add_vec(4'd5,  1'b0, 95, 1'b0);
        add_vec(4'd6,  1'b0, T_OVF1, 1'b1);
        add_vec(4'd8,  1'b0, T_OVF2, 1'b1);
        add_vec(4'd12, 1'b0, T_OVF2, 1'b1);
        add_vec(4'd0,  1'b1, 0,  1'b0);

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        tick;
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.sv", 32'(sum_valid), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk_total("rst", 0);

        foreach (vecs[i]) begin
            if (vecs[i].clr) do_clear($sformatf("v%0d", i));
            send(vecs[i].opnd, vecs[i].total, vecs[i].ovf, $sformatf("v%0d", i));
        end

        // clear and in_valid together in IDLE: operand must be refused
        send(4'd4, 4, 1'b0, "pre_cv");
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd2;
        tick;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("cv.ready", 32'(in_ready), 32'd1);
        chk_total("cv", 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("cv.sv%0d", k), 32'(sum_valid), 32'd0);
        end
        chk_total("cv_end", 0);

        // Held in_valid with 3s; clear lands in ADD_TENS of the third operand
        sv_mask  = 16'b0100_0000_1000_1000;
        rdy_mask = 16'b1000_1001_0001_0000;
        in_valid = 1'b1;
        in_data  = 4'd3;
        for (int k = 1; k <= 15; k++) begin
            tick;
            chk($sformatf("thr.sv%0d", k), 32'(sum_valid), 32'(sv_mask[k]));
            chk($sformatf("thr.rdy%0d", k), 32'(in_ready), 32'(rdy_mask[k]));
            if (k == 8)  chk_total("thr8", 6);
            if (k == 11) chk_total("thr11", 0);
            if (k == 15) chk_total("thr15", 3);
            if (k == 10) clear = 1'b1;
            if (k == 11) clear = 1'b0;
            if (k == 15) in_valid = 1'b0;
        end

        // Reset mid-operation loses the in-flight operand
        in_valid = 1'b1;
        in_data  = 4'd5;
        tick;
        in_valid = 1'b0;
        tick;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mid.ready", 32'(in_ready), 32'd1);
        chk("mid.sv", 32'(sum_valid), 32'd0);
        chk_total("mid", 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("mid.sv%0d", k), 32'(sum_valid), 32'd0);
        end
        chk_total("mid_end", 0);
        chk("mid_end.ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
